// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared sizes and types for the architectural register file
package regfile_pkg;

    localparam int REG_WIDTH  = 64;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_WIDTH-1:0]  reg_data_t;

    localparam reg_addr_t XZR_IDX = 5'd31;

endpackage

// File: rtl/regfile_wr_decoded_if.sv
// rtl/regfile_wr_decoded_if.sv - write/read port bundle of the register file
interface regfile_wr_decoded_if;
    import regfile_pkg::*;

    logic      RegWrite;
    reg_addr_t WriteRegister;
    reg_data_t WriteData;
    reg_addr_t ReadRegister1;
    reg_addr_t ReadRegister2;
    reg_data_t ReadData1;
    reg_data_t ReadData2;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/decoder1_2.sv
// rtl/decoder1_2.sv - 1:2 enabled decoder, leaf stage of the write-address tree
module decoder1_2 (
    input  logic       en,
    input  logic       in,
    output logic [1:0] out
);
    assign out[0] = en & ~in;
    assign out[1] = en &  in;
endmodule

// File: rtl/decoder2_4.sv
// rtl/decoder2_4.sv - 2:4 enabled decoder built from 1:2 stages
module decoder2_4 (
    input  logic       en,
    input  logic [1:0] in,
    output logic [3:0] out
);
    logic [1:0] hi;

    decoder1_2 u_hi  (.en(en),    .in(in[1]), .out(hi));
    decoder1_2 u_lo0 (.en(hi[0]), .in(in[0]), .out(out[1:0]));
    decoder1_2 u_lo1 (.en(hi[1]), .in(in[0]), .out(out[3:2]));
endmodule

// File: rtl/decoder3_8.sv
// rtl/decoder3_8.sv - 3:8 enabled decoder built from a 1:2 stage and two 2:4 stages
module decoder3_8 (
    input  logic       en,
    input  logic [2:0] in,
    output logic [7:0] out
);
    logic [1:0] hi;

    decoder1_2 u_hi  (.en(en),    .in(in[2]),   .out(hi));
    decoder2_4 u_lo0 (.en(hi[0]), .in(in[1:0]), .out(out[3:0]));
    decoder2_4 u_lo1 (.en(hi[1]), .in(in[1:0]), .out(out[7:4]));
endmodule

// File: rtl/decoder5_32.sv
// rtl/decoder5_32.sv - 5:32 enabled one-hot decoder: 2:4 on the top bits fanning into four 3:8 stages
module decoder5_32 (
    input  logic        en,
    input  logic [4:0]  in,
    output logic [31:0] out
);
    logic [3:0] bank_en;

    decoder2_4 u_bank (.en(en), .in(in[4:3]), .out(bank_en));

    for (genvar b = 0; b < 4; b++) begin : g_bank
        decoder3_8 u_sub (
            .en  (bank_en[b]),
            .in  (in[2:0]),
            .out (out[b*8 +: 8])
        );
    end
endmodule

// File: rtl/regfile_wr_decoded.sv
// rtl/regfile_wr_decoded.sv - 32x64 register file, decoded write port, two combinational reads, X31 = zero
// Optional write-first bypass on both read ports: define REGFILE_WR_BYPASS_EN.
module regfile_wr_decoded
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic reset,
    regfile_wr_decoded_if.slave bus
);
    logic [NUM_REGS-1:0] wr_en;
    reg_data_t           regs [NUM_REGS];
    reg_data_t           rd1;
    reg_data_t           rd2;
    logic                unused_xzr_en;

    decoder5_32 u_wr_dec (
        .en  (bus.RegWrite),
        .in  (bus.WriteRegister),
        .out (wr_en)
    );

    // The zero register has no storage, so its decoder output goes nowhere.
    assign unused_xzr_en = wr_en[XZR_IDX];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == int'(XZR_IDX)) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_store
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    regs[i] <= '0;
                end else if (wr_en[i]) begin
                    regs[i] <= bus.WriteData;
                end
            end
        end
    end

    always_comb begin
        rd1 = regs[bus.ReadRegister1];
        rd2 = regs[bus.ReadRegister2];
`ifdef REGFILE_WR_BYPASS_EN
        if (bus.RegWrite && (bus.ReadRegister1 == bus.WriteRegister)) begin
            rd1 = bus.WriteData;
        end
        if (bus.RegWrite && (bus.ReadRegister2 == bus.WriteRegister)) begin
            rd2 = bus.WriteData;
        end
`endif
        // Zero register and reset override everything, including a bypassed write.
        if (reset || (bus.ReadRegister1 == XZR_IDX)) begin
            rd1 = '0;
        end
        if (reset || (bus.ReadRegister2 == XZR_IDX)) begin
            rd2 = '0;
        end
    end

    assign bus.ReadData1 = rd1;
    assign bus.ReadData2 = rd2;
endmodule

// File: tb/tb_regfile_wr_decoded.sv
// tb/tb_regfile_wr_decoded.sv - scoreboard bench for regfile_wr_decoded
module tb_regfile_wr_decoded;
    import regfile_pkg::*;

    logic clk;
    logic reset;
    logic rd_valid;
    int   n_pass;
    int   n_total;

    regfile_wr_decoded_if bus ();

    regfile_wr_decoded dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string     name;
        reg_addr_t a1;
        reg_addr_t a2;
        reg_data_t e1;
        reg_data_t e2;
    } exp_t;

    exp_t sb [$];

`ifdef REGFILE_WR_BYPASS_EN
    localparam reg_data_t X10_PRE = 64'h22;
`else
    localparam reg_data_t X10_PRE = 64'h11;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

    function automatic void check(input string name, input reg_addr_t a,
                                  input reg_data_t act, input reg_data_t exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s addr=%0d got=%h expected=%h", name, a, act, exp);
        end
    endfunction

    // Monitor: each read strobe presents both ports; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge rd_valid);
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_underflow got=strobe expected=queued_entry");
            end else begin
                e = sb.pop_front();
                check({e.name, "_rd1"}, e.a1, bus.ReadData1, e.e1);
                check({e.name, "_rd2"}, e.a2, bus.ReadData2, e.e2);
            end
        end
    end

    task automatic rd(input string name, input reg_addr_t a1, input reg_addr_t a2,
                      input reg_data_t e1, input reg_data_t e2);
        exp_t e;
        bus.ReadRegister1 = a1;
        bus.ReadRegister2 = a2;
        #1;
        e.name = name; e.a1 = a1; e.a2 = a2; e.e1 = e1; e.e2 = e2;
        sb.push_back(e);
        rd_valid = 1'b1;
        #1;
        rd_valid = 1'b0;
    endtask

    task automatic wr(input reg_addr_t a, input reg_data_t d);
        @(negedge clk);
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = a;
        bus.WriteData     = d;
        @(negedge clk);
        bus.RegWrite      = 1'b0;
    endtask

    initial begin
        n_pass            = 0;
        n_total           = 0;
        rd_valid          = 1'b0;
        reset             = 1'b1;
        bus.RegWrite      = 1'b0;
        bus.WriteRegister = '0;
        bus.WriteData     = '0;
        bus.ReadRegister1 = '0;
        bus.ReadRegister2 = '0;

        for (int i = 0; i < NUM_REGS; i++) begin
            rd("reset", reg_addr_t'(i), reg_addr_t'(31 - i), 64'h0, 64'h0);
        end

        @(negedge clk);
        reset = 1'b0;

        wr(5'd5, 64'h0123_4567_89AB_CDEF);
        rd("basic_x5_x4", 5'd5, 5'd4, 64'h0123_4567_89AB_CDEF, 64'h0);
        rd("basic_x6_x5", 5'd6, 5'd5, 64'h0, 64'h0123_4567_89AB_CDEF);

        @(negedge clk);
        bus.RegWrite      = 1'b0;
        bus.WriteRegister = 5'd7;
        bus.WriteData     = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (3) @(negedge clk);
        rd("wr_disable_x7", 5'd7, 5'd7, 64'h0, 64'h0);

        wr(5'd30, 64'h3030_3030_3030_3030);
        @(negedge clk);
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = 5'd31;
        bus.WriteData     = 64'hDEAD_BEEF_0000_0001;
        rd("xzr_during_wr", 5'd31, 5'd31, 64'h0, 64'h0);
        @(negedge clk);
        bus.RegWrite = 1'b0;
        rd("xzr_after_wr", 5'd31, 5'd31, 64'h0, 64'h0);
        rd("x30_kept", 5'd30, 5'd31, 64'h3030_3030_3030_3030, 64'h0);

        wr(5'd10, 64'h11);
        @(negedge clk);
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = 5'd10;
        bus.WriteData     = 64'h22;
        rd("x10_pre_edge", 5'd10, 5'd10, X10_PRE, X10_PRE);
        @(negedge clk);
        bus.RegWrite = 1'b0;
        rd("x10_post_edge", 5'd10, 5'd10, 64'h22, 64'h22);

        for (int i = 0; i < 31; i++) begin
            wr(reg_addr_t'(i), reg_data_t'(i + 1));
        end
        for (int i = 0; i < 31; i++) begin
            rd("fill", reg_addr_t'(i), reg_addr_t'(30 - i),
               reg_data_t'(i + 1), reg_data_t'(31 - i));
        end

        @(negedge clk);
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = 5'd3;
        bus.WriteData     = 64'h99;
        #1;
        reset = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd("mid_reset", reg_addr_t'(i), reg_addr_t'(i), 64'h0, 64'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus.RegWrite = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd("post_reset", reg_addr_t'(i), reg_addr_t'(31 - i),
               (i == 3)      ? 64'h99 : 64'h0,
               (31 - i == 3) ? 64'h99 : 64'h0);
        end

        #2;
        n_total++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL sb_drain got=%0d expected=0 entries left", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
